mem_access_unit: RTL and testbench

Memory-stage load/store sequencer sitting directly upstream of the load shifter. Accepts one load or store per instruction from the MEM stage and forms the word-aligned memory request. For stores it generates big-endian byte enables and replicated or shifted write data. It waits on a ready handshake from data memory, stalling the pipeline meanwhile, then presents the raw read word with its byte offset and load select for the load shifter to extract.

---
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store sequencer feeding the load shifter
// Forms word-aligned requests and store lanes, waits on mem_ready, and hands the raw read word downstream.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_load_sel,
  input  logic [2:0]        req_store_sel,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic [1:0]        ld_addr,
  output logic [2:0]        ld_sel
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LW  = 3'd4;
  localparam logic [2:0] ST_SB  = 3'd0;
  localparam logic [2:0] ST_SH  = 3'd1;
  localparam logic [2:0] ST_SW  = 3'd2;
  localparam logic [2:0] ST_SWL = 3'd3;
  localparam logic [2:0] ST_SWR = 3'd4;

  state_e state_q, state_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        sel_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       ld_data_q;
  logic [1:0]        ld_addr_q;
  logic [2:0]        ld_sel_q;

  logic [1:0]  byte_off;
  logic [1:0]  byte_off_inv;
  logic        addr_bad;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        accept;
  logic        capture;

  assign byte_off     = req_addr[1:0];
  assign byte_off_inv = 2'd3 - byte_off;

  always_comb begin : misalign_check
    addr_bad = 1'b0;
    if (req_we) begin
      case (req_store_sel)
        ST_SH:   addr_bad = byte_off[0];
        ST_SW:   addr_bad = |byte_off;
        default: addr_bad = 1'b0;
      endcase
    end else begin
      case (req_load_sel)
        LD_LH, LD_LHU: addr_bad = byte_off[0];
        LD_LW:         addr_bad = |byte_off;
        default:       addr_bad = 1'b0;
      endcase
    end
  end

  // Big-endian lanes: be[3] is byte offset 0 (bits 31:24).
  always_comb begin : store_format
    st_be    = 4'b1111;
    st_wdata = req_wdata;
    case (req_store_sel)
      ST_SB: begin
        st_be    = 4'b1000 >> byte_off;
        st_wdata = {4{req_wdata[7:0]}};
      end
      ST_SH: begin
        st_be    = byte_off[1] ? 4'b0011 : 4'b1100;
        st_wdata = {2{req_wdata[15:0]}};
      end
      ST_SWL: begin
        st_be    = 4'b1111 >> byte_off;
        st_wdata = req_wdata >> {byte_off, 3'b000};
      end
      ST_SWR: begin
        st_be    = 4'b1111 << byte_off_inv;
        st_wdata = req_wdata << {byte_off_inv, 3'b000};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
      end
    endcase
  end

  assign accept  = (state_q == S_IDLE) && req_valid && !addr_bad;
  assign capture = (state_q == S_BUSY) && mem_ready;

  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = accept ? S_BUSY : S_IDLE;
      S_BUSY:  state_d = mem_ready ? S_DONE : S_BUSY;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : fsm_outputs
    mem_req  = (state_q == S_BUSY);
    mem_we   = (state_q == S_BUSY) && we_q;
    ld_valid = (state_q == S_DONE) && !we_q;
    misalign = (state_q == S_IDLE) && req_valid && addr_bad;
    stall    = req_valid && !misalign && (state_q != S_DONE);
  end

  // Request fields are frozen at accept so the memory sees them stable across wait states.
  always_ff @(posedge clk) begin : txn_regs
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= 3'd0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      sel_q   <= req_we ? req_store_sel : req_load_sel;
      be_q    <= req_we ? st_be : 4'b1111;
      wdata_q <= req_we ? st_wdata : 32'h0;
    end
  end

  always_ff @(posedge clk) begin : load_capture
    if (rst) begin
      ld_data_q <= 32'h0;
      ld_addr_q <= 2'd0;
      ld_sel_q  <= LD_LW;
    end else if (capture && !we_q) begin
      ld_data_q <= mem_rdata;
      ld_addr_q <= addr_q[1:0];
      ld_sel_q  <= sel_q;
    end
  end

  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign ld_data   = ld_data_q;
  assign ld_addr   = ld_addr_q;
  assign ld_sel    = ld_sel_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
// Directed scenarios plus random loads/stores checked against a byte-lane reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_load_sel;
  logic [2:0]  req_store_sel;
  logic [31:0] req_wdata;
  logic        stall;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [1:0]  ld_addr;
  logic [2:0]  ld_sel;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int          o_cycles, o_stall, o_req, o_mis, o_ldv;
  bit          o_unstable, o_timeout;
  logic        o_we;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_be;
  logic [31:0] o_ld_data;
  logic [1:0]  o_ld_addr;
  logic [2:0]  o_ld_sel;

  logic [31:0] last_ld_data;
  logic [1:0]  last_ld_addr;
  logic [2:0]  last_ld_sel;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_load_sel(req_load_sel), .req_store_sel(req_store_sel), .req_wdata(req_wdata),
    .stall(stall), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_addr(ld_addr), .ld_sel(ld_sel)
  );

  function automatic bit model_misaligned(input bit we, input logic [2:0] sel, input logic [1:0] a);
    if (we) return (sel == 3'd1 && a[0]) || (sel == 3'd2 && a != 2'd0);
    return ((sel == 3'd2 || sel == 3'd3) && a[0]) || (sel == 3'd4 && a != 2'd0);
  endfunction

  // Lane i is byte offset i (lane 0 = bits 31:24); rb[k] is the k-th most significant byte of rt.
  function automatic void model_store(input logic [2:0] sel, input logic [1:0] a, input logic [31:0] rt,
                                      output logic [3:0] be, output logic [31:0] wd);
    logic [7:0] rb [4];
    int ai;
    bit on;
    logic [7:0] lane;
    ai = int'(a);
    for (int k = 0; k < 4; k++) rb[k] = rt[31-8*k -: 8];
    be = 4'b0000;
    wd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      case (sel)
        3'd0: begin on = (i == ai); lane = rt[7:0]; end
        3'd1: begin on = (i / 2 == ai / 2); lane = (i % 2 == 0) ? rt[15:8] : rt[7:0]; end
        3'd3: begin on = (i >= ai); lane = on ? rb[i-ai] : 8'h00; end
        3'd4: begin on = (i <= ai); lane = on ? rb[i+3-ai] : 8'h00; end
        default: begin on = 1'b1; lane = rb[i]; end
      endcase
      be[3-i] = on;
      wd[31-8*i -: 8] = lane;
    end
  endfunction

  // Plays the MEM stage (holds the instruction while stalled) and the data memory.
  task automatic drive_txn(input bit we, input logic [31:0] addr, input logic [2:0] sel,
                           input logic [31:0] wd, input int waits, input logic [31:0] rd);
    int busy_n;
    bit adv;
    busy_n = 0; adv = 1'b0;
    o_cycles = 0; o_stall = 0; o_req = 0; o_mis = 0; o_ldv = 0;
    o_unstable = 1'b0; o_timeout = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    req_load_sel  = we ? 3'($urandom_range(0, 6)) : sel;
    req_store_sel = we ? sel : 3'($urandom_range(0, 4));
    mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    while (!adv && o_cycles < 40) begin
      #1;
      if (mem_req === 1'b1) begin
        if (o_req == 0) begin
          o_we = mem_we; o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata;
        end else if ({mem_we, mem_addr, mem_be, mem_wdata} !== {o_we, o_addr, o_be, o_wdata}) begin
          o_unstable = 1'b1;
        end
        o_req++;
        mem_ready = (busy_n == waits);
        mem_rdata = mem_ready ? rd : $urandom;
        busy_n++;
        req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom_range(0, 1));
        req_load_sel = 3'($urandom_range(0, 6)); req_store_sel = 3'($urandom_range(0, 4));
      end else begin
        mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      end
      #1;
      o_cycles++;
      if (stall === 1'b1) o_stall++;
      if (misalign === 1'b1) o_mis++;
      if (ld_valid === 1'b1) begin
        o_ldv++; o_ld_data = ld_data; o_ld_addr = ld_addr; o_ld_sel = ld_sel;
      end
      adv = (stall === 1'b0);
      @(negedge clk);
    end
    if (!adv) o_timeout = 1'b1;
    req_valid = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
    req_load_sel = 3'd4; req_store_sel = 3'd0; req_wdata = $urandom;
    mem_ready = 1'b1; mem_rdata = $urandom;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_dominates mem_req got=%b exp=0", mem_req); end
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, ld_valid, stall, misalign} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {mem_req, mem_we, ld_valid, stall, misalign});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 || ld_data !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", mem_addr, mem_be, mem_wdata, ld_data);
    end
    checks++;
    if (ld_addr !== 2'd0 || ld_sel !== 3'd4) begin
      failures++; $display("FAIL reset_ld got addr=%0d sel=%0d exp addr=0 sel=4", ld_addr, ld_sel);
    end
    last_ld_data = 32'h0; last_ld_addr = 2'd0; last_ld_sel = 3'd4;
    @(negedge clk);
  endtask

  task automatic test_lw_basic();
    drive_txn(1'b0, 32'h100, 3'd4, $urandom, 0, 32'hDEADBEEF);
    checks++;
    if (o_stall != 2 || o_timeout) begin failures++; $display("FAIL lw_stall got=%0d exp=2", o_stall); end
    checks++;
    if (o_req != 1 || o_addr !== 32'h100 || o_be !== 4'hF || o_we !== 1'b0) begin
      failures++; $display("FAIL lw_req got req=%0d addr=%h be=%h we=%b exp 1/00000100/f/0", o_req, o_addr, o_be, o_we);
    end
    checks++;
    if (o_ldv != 1 || o_ld_data !== 32'hDEADBEEF || o_ld_addr !== 2'd0 || o_ld_sel !== 3'd4) begin
      failures++; $display("FAIL lw_ld got v=%0d d=%h a=%0d s=%0d exp 1/deadbeef/0/4", o_ldv, o_ld_data, o_ld_addr, o_ld_sel);
    end
    last_ld_data = 32'hDEADBEEF; last_ld_addr = 2'd0; last_ld_sel = 3'd4;
  endtask

  task automatic test_sb();
    drive_txn(1'b1, 32'h203, 3'd0, 32'h123456AB, 0, $urandom);
    checks++;
    if (o_addr !== 32'h200 || o_be !== 4'b0001 || o_wdata !== 32'hABABABAB || o_we !== 1'b1) begin
      failures++; $display("FAIL sb_fields got addr=%h be=%b wd=%h we=%b exp 00000200/0001/abababab/1", o_addr, o_be, o_wdata, o_we);
    end
    checks++;
    if (o_ldv != 0 || ld_data !== last_ld_data || ld_sel !== last_ld_sel) begin
      failures++; $display("FAIL sb_no_load got ldv=%0d ld_data=%h exp ldv=0 ld_data=%h", o_ldv, ld_data, last_ld_data);
    end
  endtask

  task automatic test_swl_swr();
    drive_txn(1'b1, 32'h301, 3'd3, 32'hAABBCCDD, 1, $urandom);
    checks++;
    if (o_be !== 4'b0111 || o_wdata !== 32'h00AABBCC) begin
      failures++; $display("FAIL swl got be=%b wd=%h exp 0111/00aabbcc", o_be, o_wdata);
    end
    drive_txn(1'b1, 32'h301, 3'd4, 32'hAABBCCDD, 0, $urandom);
    checks++;
    if (o_be !== 4'b1100 || o_wdata !== 32'hCCDD0000) begin
      failures++; $display("FAIL swr got be=%b wd=%h exp 1100/ccdd0000", o_be, o_wdata);
    end
  endtask

  task automatic test_misalign();
    drive_txn(1'b0, 32'h101, 3'd2, $urandom, 0, $urandom);
    #1;
    checks++;
    if (o_mis != 1 || o_stall != 0 || o_req != 0 || o_cycles != 1 || mem_req !== 1'b0) begin
      failures++; $display("FAIL lh_misalign got mis=%0d stall=%0d req=%0d cyc=%0d exp 1/0/0/1", o_mis, o_stall, o_req, o_cycles);
    end
    @(negedge clk);
    drive_txn(1'b1, 32'h102, 3'd2, $urandom, 0, $urandom);
    #1;
    checks++;
    if (o_mis != 1 || o_stall != 0 || o_req != 0 || o_cycles != 1 || mem_req !== 1'b0) begin
      failures++; $display("FAIL sw_misalign got mis=%0d stall=%0d req=%0d cyc=%0d exp 1/0/0/1", o_mis, o_stall, o_req, o_cycles);
    end
    @(negedge clk);
  endtask

  task automatic test_lbu_wait();
    logic [31:0] rd;
    rd = $urandom;
    drive_txn(1'b0, 32'h42, 3'd1, $urandom, 3, rd);
    checks++;
    if (o_stall != 5 || o_req != 4 || o_unstable) begin
      failures++; $display("FAIL lbu_wait got stall=%0d req=%0d unstable=%b exp 5/4/0", o_stall, o_req, o_unstable);
    end
    checks++;
    if (o_ldv != 1 || o_ld_data !== rd || o_ld_addr !== 2'd2 || o_ld_sel !== 3'd1 || o_addr !== 32'h40) begin
      failures++; $display("FAIL lbu_ld got d=%h a=%0d s=%0d maddr=%h exp %h/2/1/00000040", o_ld_data, o_ld_addr, o_ld_sel, o_addr, rd);
    end
    last_ld_data = rd; last_ld_addr = 2'd2; last_ld_sel = 3'd1;
  endtask

  task automatic test_reset_busy();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h80; req_load_sel = 3'd4; mem_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_busy_first got=%b exp=1", mem_req); end
    @(negedge clk);
    rst = 1'b1; #1;
    checks++;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_busy_second got=%b exp=1", mem_req); end
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; mem_ready = 1'b1; mem_rdata = $urandom; #1;
    checks++;
    if (mem_req !== 1'b0 || ld_valid !== 1'b0 || ld_data !== 32'h0) begin
      failures++; $display("FAIL rst_busy_drop got req=%b ldv=%b ld_data=%h exp 0/0/0", mem_req, ld_valid, ld_data);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b0 || ld_valid !== 1'b0) begin
      failures++; $display("FAIL rst_busy_idle got req=%b ldv=%b exp 0/0", mem_req, ld_valid);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    drive_txn(1'b0, 32'h104, 3'd4, $urandom, 0, 32'hCAFEF00D);
    checks++;
    if (o_stall != 2 || o_ldv != 1 || o_ld_data !== 32'hCAFEF00D || o_ld_addr !== 2'd0) begin
      failures++; $display("FAIL rst_busy_after got stall=%0d ldv=%0d d=%h exp 2/1/cafef00d", o_stall, o_ldv, o_ld_data);
    end
    last_ld_data = 32'hCAFEF00D; last_ld_addr = 2'd0; last_ld_sel = 3'd4;
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      drive_txn(n[0], {24'h0, 6'($urandom), 2'b00}, 3'd2 + 3'(n[0] ? 0 : 2), $urandom, 0, $urandom);
      checks++;
      if (o_cycles != 3 || o_stall != 2 || o_timeout) begin
        failures++; $display("FAIL back_to_back[%0d] got cycles=%0d stall=%0d exp 3/2", n, o_cycles, o_stall);
      end
      if (!n[0]) begin last_ld_data = o_ld_data; last_ld_addr = 2'd0; last_ld_sel = 3'd4; end
    end
  endtask

  task automatic test_random();
    bit          we, mis;
    logic [2:0]  sel;
    logic [31:0] addr, wd, rd, exp_wd;
    logic [3:0]  exp_be;
    int          waits;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      sel = we ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 6));
      addr = $urandom; wd = $urandom; rd = $urandom;
      waits = $urandom_range(0, 3);
      mis = model_misaligned(we, sel, addr[1:0]);
      model_store(sel, addr[1:0], wd, exp_be, exp_wd);
      if (!we) exp_be = 4'b1111;
      drive_txn(we, addr, sel, wd, waits, rd);
      checks++;
      if (o_timeout || o_cycles != (mis ? 1 : waits + 3) || o_stall != (mis ? 0 : waits + 2)) begin
        failures++; $display("FAIL rand[%0d]_timing got cycles=%0d stall=%0d mis=%b waits=%0d", n, o_cycles, o_stall, mis, waits);
      end
      checks++;
      if (o_mis != int'(mis) || o_req != (mis ? 0 : waits + 1) || o_unstable) begin
        failures++; $display("FAIL rand[%0d]_req got mis=%0d req=%0d unstable=%b exp mis=%b req=%0d", n, o_mis, o_req, o_unstable, mis, mis ? 0 : waits + 1);
      end
      if (!mis) begin
        checks++;
        if (o_addr !== {addr[31:2], 2'b00} || o_be !== exp_be || o_we !== we || (we && o_wdata !== exp_wd)) begin
          failures++; $display("FAIL rand[%0d]_fields sel=%0d addr=%h got %h/%b/%h/%b exp %h/%b/%h/%b", n, sel, addr,
                               o_addr, o_be, o_wdata, o_we, {addr[31:2], 2'b00}, exp_be, exp_wd, we);
        end
        if (!we) begin last_ld_data = rd; last_ld_addr = addr[1:0]; last_ld_sel = sel; end
      end
      checks++;
      if (o_ldv != ((!we && !mis) ? 1 : 0) || ld_data !== last_ld_data || ld_addr !== last_ld_addr || ld_sel !== last_ld_sel) begin
        failures++; $display("FAIL rand[%0d]_ld got v=%0d %h/%0d/%0d exp %h/%0d/%0d", n, o_ldv, ld_data, ld_addr, ld_sel,
                             last_ld_data, last_ld_addr, last_ld_sel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_basic();
    test_sb();
    test_swl_swr();
    test_misalign();
    test_lbu_wait();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
